// File: rtl/aespim_ctx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aespim_ctx_engine                                                          |
// | Multi-context AES column-state engine with a lane-serial S-box datapath.   |
// | Optional opcode 7 (DECF) is enabled by defining AESPIM_DECF_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module aespim_bsbox (
    input  logic       i_encrypt,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv_in;
    logic [7:0] w_inv;

    // One shared inverter; affine on the way out for encrypt, on the way in for decrypt.
    always_comb begin
        w_pre    = {i_data[6:0], i_data[7]} ^ {i_data[4:0], i_data[7:5]} ^
                   {i_data[1:0], i_data[7:2]} ^ 8'h05;
        w_inv_in = i_encrypt ? i_data : w_pre;
        w_inv    = gf_inv(w_inv_in);
        if (i_encrypt)
            o_data = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                     {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
        else
            o_data = w_inv;
    end
endmodule

module aespim_ctx_engine #(
    parameter int NUM_CTX = 2,
    parameter int LANES   = 4,
    localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CTX_W-1:0] cmd_ctx_i,
    input  logic [2:0]       cmd_op_i,
    input  logic [1:0]       cmd_sr_i,
    input  logic [31:0]      cmd_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [CTX_W-1:0] rsp_ctx_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam logic [2:0] c_OP_LD   = 3'd0;
    localparam logic [2:0] c_OP_ST   = 3'd1;
    localparam logic [2:0] c_OP_KEXI = 3'd2;
    localparam logic [2:0] c_OP_KEX  = 3'd3;
    localparam logic [2:0] c_OP_ENCI = 3'd4;
    localparam logic [2:0] c_OP_ENCM = 3'd5;
    localparam logic [2:0] c_OP_DECF = 3'd7;
    localparam logic [1:0] c_SUB_LAST = 2'(4 / LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUB    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0][31:0] r_w  [NUM_CTX];
    logic [3:0]       r_ri [NUM_CTX];

    logic [CTX_W-1:0] r_ctx;
    logic [2:0]       r_op;
    logic [1:0]       r_sr;
    logic [31:0]      r_data;
    logic [31:0]      r_src;
    logic [31:0]      r_res;
    logic [1:0]       r_cnt;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic [CTX_W-1:0] r_rsp_ctx;
    logic             r_err;

    logic             w_op_ok;
    logic             w_ctx_ok;
    logic             w_accept;
    logic             w_go;
    logic             w_is_sbox;
    logic             w_commit;
    logic             w_sbox_enc;
    logic [CTX_W-1:0] w_c_ctx;
    logic [2:0]       w_c_op;
    logic [1:0]       w_c_sr;
    logic [31:0]      w_c_data;
    logic [3:0][31:0] w_cur;
    logic [3:0]       w_cur_ri;
    logic [3:0][31:0] w_nxt;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    int               w_pos;
    logic [8*LANES-1:0] w_sbox_in;
    logic [8*LANES-1:0] w_sbox_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = w;
        return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] ri);
        case (ri)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef AESPIM_DECF_EN
    assign w_op_ok    = 1'b1;
    assign w_sbox_enc = (r_op != c_OP_DECF);
`else
    assign w_op_ok    = (cmd_op_i != c_OP_DECF);
    assign w_sbox_enc = 1'b1;
`endif

    assign w_ctx_ok  = (int'(cmd_ctx_i) < NUM_CTX);
    assign w_accept  = cmd_valid_i & cmd_ready_o;
    assign w_go      = w_accept & w_ctx_ok & w_op_ok;
    assign w_is_sbox = (cmd_op_i == c_OP_KEXI) | (cmd_op_i >= c_OP_ENCM);
    assign w_commit  = (w_go & ~w_is_sbox) | (r_state == ST_COMMIT);

    // Immediate ops commit straight from the command bus; S-box ops from the latched copy.
    assign w_c_ctx  = (r_state == ST_COMMIT) ? r_ctx  : cmd_ctx_i;
    assign w_c_op   = (r_state == ST_COMMIT) ? r_op   : cmd_op_i;
    assign w_c_sr   = (r_state == ST_COMMIT) ? r_sr   : cmd_sr_i;
    assign w_c_data = (r_state == ST_COMMIT) ? r_data : cmd_data_i;

    always_comb begin
        w_cur    = r_w[0];
        w_cur_ri = r_ri[0];
        for (int c = 1; c < NUM_CTX; c++) begin
            if (w_c_ctx == CTX_W'(c)) begin
                w_cur    = r_w[c];
                w_cur_ri = r_ri[c];
            end
        end
    end

    always_comb begin
        w_a = 32'h0;
        w_b = 32'h0;
        case (w_c_op)
            c_OP_LD:   w_a = w_c_data;
            c_OP_ST:   w_a = w_cur[0];
            c_OP_KEXI: begin
                w_a = w_cur[0];
                w_b = {r_res[23:0], r_res[31:24]} ^ {rcon(w_cur_ri), 24'h0};
            end
            c_OP_KEX: begin
                w_a = w_cur[0];
                w_b = w_cur[0];
            end
            c_OP_ENCI: w_a = w_c_data ^ w_cur[0];
            c_OP_ENCM: w_a = w_c_data ^ mix_col(r_res);
            default:   w_a = w_c_data ^ r_res;
        endcase
    end

    // Per byte lane, A is inserted at word w_pos; words below it shift down one place.
    always_comb begin
        w_nxt = w_cur;
        w_pos = 3;
        for (int l = 0; l < 4; l++) begin
            w_pos = (l < int'(w_c_sr)) ? 2 - l : 3;
            for (int k = 0; k < 4; k++) begin
                if (k == w_pos) begin
                    w_nxt[k][8*l +: 8] = w_a[8*l +: 8];
                end else if (k < w_pos) begin
                    if (k == 0)
                        w_nxt[0][8*l +: 8] = w_cur[1][8*l +: 8] ^ w_b[8*l +: 8];
                    else
                        w_nxt[k][8*l +: 8] = w_cur[(k < 3) ? k + 1 : 3][8*l +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_go && w_is_sbox) w_state_nxt = ST_SUB;
            ST_SUB:    if (r_cnt == c_SUB_LAST) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    assign w_sbox_in = r_src[int'(r_cnt)*8*LANES +: 8*LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aespim_bsbox u_sbox (
            .i_encrypt (w_sbox_enc),
            .i_data    (w_sbox_in[8*g +: 8]),
            .o_data    (w_sbox_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctx  <= '0;
            r_op   <= 3'd0;
            r_sr   <= 2'd0;
            r_data <= 32'h0;
            r_src  <= 32'h0;
            r_res  <= 32'h0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_go && w_is_sbox) begin
                r_ctx  <= cmd_ctx_i;
                r_op   <= cmd_op_i;
                r_sr   <= cmd_sr_i;
                r_data <= cmd_data_i;
                r_src  <= w_cur[0];
            end
            if (r_state == ST_SUB) begin
                r_cnt <= r_cnt + 2'd1;
                r_res[int'(r_cnt)*8*LANES +: 8*LANES] <= w_sbox_out;
            end else begin
                r_cnt <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                r_w[c]  <= '0;
                r_ri[c] <= 4'd0;
            end
        end else if (w_commit) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                if (w_c_ctx == CTX_W'(c)) begin
                    r_w[c] <= w_nxt;
                    if (w_c_op == c_OP_KEXI)
                        r_ri[c] <= (w_cur_ri == 4'd9) ? 4'd0 : w_cur_ri + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_ctx   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept & ~(w_ctx_ok & w_op_ok);
            if (w_go && cmd_op_i == c_OP_ST) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_cur[0];
                r_rsp_ctx   <= cmd_ctx_i;
            end else if (rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = (r_state == ST_IDLE) & (~r_rsp_valid | rsp_ready_i);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_ctx_o   = r_rsp_ctx;
    assign busy_o      = (r_state != ST_IDLE);
    assign err_o       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_aespim_ctx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aespim_ctx_engine                                                       |
// | Directed plus random stimulus against a table-driven behavioural model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aespim_ctx_engine;
    localparam int NCTX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ctx;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_sr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_ctx;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    aespim_ctx_engine #(.NUM_CTX(NCTX), .LANES(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_ctx_i   (cmd_ctx),
        .cmd_op_i    (cmd_op),
        .cmd_sr_i    (cmd_sr),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_ctx_o   (rsp_ctx),
        .busy_o      (busy),
        .err_o       (err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] mw  [4][4];
    int          mri [4];
    logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = 15'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic enc);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = enc ? sb[w[8*l +: 8]] : isb[w[8*l +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] mixc(input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  acc;
        int          d;
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                d = (j - i + 4) % 4;
                acc = acc ^ gmul((d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01, w[8*j +: 8]);
            end
            r[8*i +: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic legal(input int c, input int o);
        return (c < NCTX) && (o != 7);
    endfunction

    function automatic logic is_sbox(input int o);
        return (o == 2) || (o >= 5);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mri[c] = 0;
            for (int k = 0; k < 4; k++) mw[c][k] = 32'h0;
        end
    endtask

    // Each byte column is a short queue: A enters at position p, the slice below drops one.
    task automatic mcommit(input int c, input int o, input int s, input logic [31:0] d);
        logic [31:0] w0, sv, a, b;
        logic [7:0]  q[$];
        int          p;
        w0 = mw[c][0];
        sv = sub_word(w0, o != 7);
        a = 32'h0;
        b = 32'h0;
        case (o)
            0: a = d;
            1: a = w0;
            2: begin a = w0; b = {sv[23:0], sv[31:24]} ^ {rcon_t[mri[c]], 24'h0}; end
            3: begin a = w0; b = w0; end
            4: a = d ^ w0;
            5: a = d ^ mixc(sv);
            default: a = d ^ sv;
        endcase
        for (int l = 0; l < 4; l++) begin
            p = (l < s) ? 2 - l : 3;
            q = {};
            for (int k = 1; k <= p; k++) q.push_back(mw[c][k][8*l +: 8]);
            q.push_back(a[8*l +: 8]);
            if (p > 0) q[0] = q[0] ^ b[8*l +: 8];
            for (int k = 0; k <= p; k++) mw[c][k][8*l +: 8] = q[k];
        end
        if (o == 2) mri[c] = (mri[c] + 1) % 10;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_ctx", rsp_ctx, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
    endtask

    task automatic send(input int c, input int o, input int s, input logic [31:0] d);
        int          n;
        logic        lg;
        logic [31:0] exp_rsp;
        cmd_valid = 1'b1;
        cmd_ctx   = 2'(c);
        cmd_op    = 3'(o);
        cmd_sr    = 2'(s);
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom();
        lg = legal(c, o);
        exp_rsp = mw[c][0];
        check("err", err, !lg);
        if (lg) mcommit(c, o, s, d);
        if (lg && o == 1) begin
            check("st_valid", rsp_valid, 1'b1);
            check("st_data", rsp_data, exp_rsp);
            check("st_ctx", rsp_ctx, 32'(c));
        end
        if (lg && is_sbox(o)) begin
            for (int i = 0; i < 5; i++) begin
                check("sub_busy", busy, 1'b1);
                check("sub_ready_low", cmd_ready, 1'b0);
                @(posedge clk);
                #1;
            end
            check("sub_busy_end", busy, 1'b0);
            check("sub_ready_end", cmd_ready, 1'b1);
        end else if (!lg) begin
            @(posedge clk);
            #1;
            check("err_pulse_end", err, 1'b0);
        end
    endtask

    task automatic dump(input int c);
        for (int i = 0; i < 4; i++) send(c, 1, 0, $urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  inv;
        logic [31:0] exp2;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = affine(inv);
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
        cmd_ctx = 2'd0;
        cmd_op = 3'd0;
        cmd_sr = 2'd0;
        cmd_data = 32'h0;

        do_reset();
        for (int i = 1; i <= 4; i++) send(0, 0, 0, 32'(i));
        send(0, 1, 0, 32'h0);
        check("ld_st_first", rsp_data, 32'h00000001);

        do_reset();
        send(0, 6, 0, 32'h0);
        dump(0);
        check("encf_st4", rsp_data, 32'h63636363);

        do_reset();
        send(1, 0, 0, 32'haaaaaaaa);
        for (int i = 0; i < 4; i++) begin
            send(0, 1, 0, 32'h0);
            check("ctx_isolation", rsp_data, 32'h0);
        end

        do_reset();
        send(2, 0, 0, 32'h11111111);
        send(2, 0, 0, 32'h22222222);
        send(2, 0, 0, 32'h33333333);
        send(2, 0, 0, 32'h44444444);
        rsp_ready = 1'b0;
        send(2, 1, 0, 32'h0);
        cmd_valid = 1'b1;
        cmd_ctx = 2'd2;
        cmd_op = 3'd1;
        cmd_sr = 2'd0;
        #1;
        check("bp_ready_low", cmd_ready, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_ready_held", cmd_ready, 1'b0);
            check("bp_rsp_held", rsp_data, 32'h11111111);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_release", cmd_ready, 1'b1);
        exp2 = mw[2][0];
        mcommit(2, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_second_valid", rsp_valid, 1'b1);
        check("bp_second_data", rsp_data, exp2);
        check("bp_second_const", rsp_data, 32'h22222222);
        @(posedge clk);
        #1;
        check("bp_drained", rsp_valid, 1'b0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            send(0, 2, 0, $urandom());
            send(0, 1, 0, 32'h0);
            if (i == 0) check("kexi_rcon_first", rsp_data, 32'h62636363);
            for (int j = 0; j < 3; j++) send(0, 1, 0, 32'h0);
        end

        send(3, 0, 0, 32'hdeadbeef);
        send(0, 7, 0, 32'h12345678);
        dump(0);
        dump(1);

        for (int i = 0; i < 300; i++)
            send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), $urandom());
        for (int c = 0; c < NCTX; c++) dump(c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
